// File: rtl/timer_light_pkg.sv
// Shared types and helpers for the multi-channel timer light.
package timer_light_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      ON   = 2'd1,
      WARN = 2'd2
   } state_t;

   localparam int TIMER_W_MIN = 1;

   // Width of the per-channel down-counter; never below one bit.
   function automatic int timer_width(input int on_period);
      int w;
      w = $clog2(on_period);
      return (w < TIMER_W_MIN) ? TIMER_W_MIN : w;
   endfunction

endpackage

// File: rtl/timer_light_channel.sv
// One timer-light channel: button edge detect, OFF/ON/WARN FSM, down-counter
// and registered-state output decode.
//
// state | meaning
// OFF   | light dark, waiting for a button rise
// ON    | light steady, timer counting down
// WARN  | last WARN_PERIOD cycles of the period, light blinking
module timer_light_channel
   import timer_light_pkg::*;
#(
   parameter int ON_PERIOD   = 30,
   parameter int WARN_PERIOD = 6,
   parameter int BLINK_HALF  = 2,
   parameter int RETRIGGER   = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic all_off,
   input  logic push_btn,
   output logic light,
   output logic warn
);

   localparam int TW = timer_width(ON_PERIOD);
   localparam logic [TW-1:0] RELOAD = TW'(ON_PERIOD - 1);

   state_t        state;
   state_t        state_n;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_n;
   logic          push_q;
   logic          rise;
   int            blink_k;

   assign rise = push_btn & ~push_q;

   // A button held through reset must not look like a fresh press.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= ON;
         timer  <= RELOAD;
         push_q <= 1'b1;
      end else begin
         state  <= state_n;
         timer  <= timer_n;
         push_q <= push_btn;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      if (all_off) begin
         state_n = OFF;
         timer_n = '0;
      end else if (state == OFF) begin
         if (rise) begin
            state_n = ON;
            timer_n = RELOAD;
         end
      end else if (state == WARN && rise) begin
         state_n = ON;
         timer_n = RELOAD;
      end else if (state == ON && rise && RETRIGGER != 0) begin
         state_n = ON;
         timer_n = RELOAD;
      end else if (timer == '0) begin
         state_n = OFF;
      end else begin
         timer_n = timer - 1'b1;
         state_n = (int'(timer_n) < WARN_PERIOD) ? WARN : ON;
      end
   end

   // k counts up from 0 on the first WARN cycle, so the blink starts dark.
   always_comb begin
      light   = 1'b0;
      warn    = 1'b0;
      blink_k = 0;
      case (state)
         ON: begin
            light = 1'b1;
         end
         WARN: begin
            warn    = 1'b1;
            blink_k = WARN_PERIOD - 1 - int'(timer);
            light   = ((blink_k / BLINK_HALF) % 2) == 1;
         end
         default: begin
            light = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/timer_light_multi.sv
// N_CH independent timer-light channels sharing clock, reset and all_off.
module timer_light_multi
   import timer_light_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int ON_PERIOD   = 30,
   parameter int WARN_PERIOD = 6,
   parameter int BLINK_HALF  = 2,
   parameter int RETRIGGER   = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_CH-1:0] push_btn,
   input  logic            all_off,
   output logic [N_CH-1:0] light,
   output logic [N_CH-1:0] warn
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timer_light_channel #(
         .ON_PERIOD   (ON_PERIOD),
         .WARN_PERIOD (WARN_PERIOD),
         .BLINK_HALF  (BLINK_HALF),
         .RETRIGGER   (RETRIGGER)
      ) u_ch (
         .clock    (clock),
         .reset    (reset),
         .all_off  (all_off),
         .push_btn (push_btn[i]),
         .light    (light[i]),
         .warn     (warn[i])
      );
   end

endmodule

// File: tb/tb_timer_light_multi.sv
// Bench for timer_light_multi: three builds (default, no retrigger, no warning)
// driven with shared stimulus and compared against a remaining-lit-cycles model.
module tb_timer_light_multi;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       all_off = 1'b0;
   logic [3:0] push_btn = 4'b0000;
   logic [3:0] light_a, warn_a, light_b, warn_b, light_c, warn_c;

   int n_checks = 0;
   int n_errors = 0;

   int         ra[4];
   int         rb[4];
   int         rc[4];
   logic [3:0] pq = 4'hF;

   always #5 clock = ~clock;

   timer_light_multi #(.N_CH(4), .ON_PERIOD(30), .WARN_PERIOD(6), .BLINK_HALF(2), .RETRIGGER(1))
   dut_a (.clock(clock), .reset(reset), .push_btn(push_btn), .all_off(all_off),
          .light(light_a), .warn(warn_a));

   timer_light_multi #(.N_CH(4), .ON_PERIOD(30), .WARN_PERIOD(6), .BLINK_HALF(2), .RETRIGGER(0))
   dut_b (.clock(clock), .reset(reset), .push_btn(push_btn), .all_off(all_off),
          .light(light_b), .warn(warn_b));

   timer_light_multi #(.N_CH(4), .ON_PERIOD(30), .WARN_PERIOD(0), .BLINK_HALF(2), .RETRIGGER(1))
   dut_c (.clock(clock), .reset(reset), .push_btn(push_btn), .all_off(all_off),
          .light(light_c), .warn(warn_c));

   // Model: r = lit cycles still to show including the current one (0 = dark).
   function automatic int next_r(int r, logic rise, logic rst, logic aoff,
                                 int onp, int wp, logic retrig);
      if (rst) return onp;
      if (aoff) return 0;
      if (rise === 1'b1 && (r == 0 || r <= wp || retrig)) return onp;
      if (r > 0) return r - 1;
      return 0;
   endfunction

   function automatic logic m_light(int r, int wp, int bh);
      if (r == 0) return 1'b0;
      if (r > wp) return 1'b1;
      return (((wp - r) / bh) % 2) == 1;
   endfunction

   function automatic logic m_warn(int r, int wp);
      return (r > 0) && (r <= wp);
   endfunction

   // Expected {light, warn} on cycle c (1 = first cycle after the starting edge).
   function automatic logic [1:0] seq(int c, int wp);
      int k;
      if (c < 1 || c > 30) return 2'b00;
      if (c <= 30 - wp) return 2'b10;
      k = c - (30 - wp) - 1;
      return {(((k / 2) % 2) == 1), 1'b1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic       rise;
      logic [3:0] ela, ewa, elb, ewb, elc, ewc;
      for (int i = 0; i < 4; i++) begin
         rise  = push_btn[i] & ~pq[i];
         ra[i] = next_r(ra[i], rise, reset, all_off, 30, 6, 1'b1);
         rb[i] = next_r(rb[i], rise, reset, all_off, 30, 6, 1'b0);
         rc[i] = next_r(rc[i], rise, reset, all_off, 30, 0, 1'b1);
      end
      pq = reset ? 4'hF : push_btn;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         ela[i] = m_light(ra[i], 6, 2);  ewa[i] = m_warn(ra[i], 6);
         elb[i] = m_light(rb[i], 6, 2);  ewb[i] = m_warn(rb[i], 6);
         elc[i] = m_light(rc[i], 0, 2);  ewc[i] = m_warn(rc[i], 0);
      end
      check("model_a_light", 32'(light_a), 32'(ela));
      check("model_a_warn",  32'(warn_a),  32'(ewa));
      check("model_b_light", 32'(light_b), 32'(elb));
      check("model_b_warn",  32'(warn_b),  32'(ewb));
      check("model_c_light", 32'(light_c), 32'(elc));
      check("model_c_warn",  32'(warn_c),  32'(ewc));
   endtask

   typedef struct {
      logic       rst;
      logic       aoff;
      logic [3:0] btn;
      logic [3:0] exp_light;
      logic [3:0] exp_warn;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [1:0] e;
      int         lit_c;

      tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000};
      tbl[1]  = '{1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000};
      tbl[2]  = '{1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000};
      tbl[3]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      tbl[4]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 4'b0000};
      tbl[5]  = '{1'b0, 1'b0, 4'b0001, 4'b1001, 4'b0000};
      tbl[6]  = '{1'b0, 1'b0, 4'b0001, 4'b1001, 4'b0000};
      tbl[7]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
      tbl[8]  = '{1'b1, 1'b0, 4'b0011, 4'b1111, 4'b0000};
      tbl[9]  = '{1'b0, 1'b0, 4'b0011, 4'b1111, 4'b0000};
      tbl[10] = '{1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0000};
      tbl[11] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      tbl[12] = '{1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000};

      for (int i = 0; i < 13; i++) begin
         reset = tbl[i].rst;  all_off = tbl[i].aoff;  push_btn = tbl[i].btn;
         tick();
         check($sformatf("tbl%0d_light", i), 32'(light_a), 32'(tbl[i].exp_light));
         check($sformatf("tbl%0d_warn", i),  32'(warn_a),  32'(tbl[i].exp_warn));
      end
      reset = 1'b0;  all_off = 1'b0;  push_btn = 4'b0000;

      // Reset timeout: 24 steady, 6 blink (00 11 00), then dark.
      for (int c = 1; c <= 36; c++) begin
         reset = (c == 1);
         tick();
         e = seq(c, 6);
         check("rst_to_light", 32'(light_a), e[1] ? 32'hF : 32'h0);
         check("rst_to_warn",  32'(warn_a),  e[0] ? 32'hF : 32'h0);
         check("rst_to_c_light", 32'(light_c), (c <= 30) ? 32'hF : 32'h0);
      end
      reset = 1'b0;

      // Single pulse on channel 0 from OFF.
      lit_c = 0;
      for (int c = 1; c <= 34; c++) begin
         push_btn = (c == 1) ? 4'b0001 : 4'b0000;
         tick();
         e = seq(c, 6);
         check("pulse0_light", 32'(light_a[0]), 32'(e[1]));
         check("pulse0_warn",  32'(warn_a[0]),  32'(e[0]));
         check("pulse0_others", 32'(light_a[3:1]), 32'h0);
         check("pulse0_c_warn", 32'(warn_c), 32'h0);
         if (light_c[0]) lit_c++;
      end
      check("nowarn_lit_count", 32'(lit_c), 32'd30);

      // Retrigger on channel 1 while ON at timer 10 (cycle 20 of its period).
      for (int c = 1; c <= 20; c++) begin
         push_btn = (c == 1) ? 4'b0010 : 4'b0000;
         tick();
      end
      for (int c = 1; c <= 32; c++) begin
         push_btn = (c == 1) ? 4'b0010 : 4'b0000;
         tick();
         e = seq(c, 6);
         check("retrig_a_light", 32'(light_a[1]), 32'(e[1]));
         check("retrig_a_warn",  32'(warn_a[1]),  32'(e[0]));
         e = seq(20 + c, 6);
         check("noretrig_b_light", 32'(light_b[1]), 32'(e[1]));
         check("noretrig_b_warn",  32'(warn_b[1]),  32'(e[0]));
      end

      // Push on channel 2 during its third WARN cycle restarts in both builds.
      for (int c = 1; c <= 27; c++) begin
         push_btn = (c == 1) ? 4'b0100 : 4'b0000;
         tick();
      end
      check("warn3_entry", 32'(warn_a[2]), 32'h1);
      for (int c = 1; c <= 32; c++) begin
         push_btn = (c == 1) ? 4'b0100 : 4'b0000;
         tick();
         e = seq(c, 6);
         check("warnre_a_light", 32'(light_a[2]), 32'(e[1]));
         check("warnre_a_warn",  32'(warn_a[2]),  32'(e[0]));
         check("warnre_b_light", 32'(light_b[2]), 32'(e[1]));
         check("warnre_b_warn",  32'(warn_b[2]),  32'(e[0]));
      end

      // all_off beats a simultaneous rise; later push lights only channel 3.
      reset = 1'b1;  tick();  reset = 1'b0;
      tick();  tick();
      all_off = 1'b1;  push_btn = 4'b1000;  tick();
      check("alloff_light", 32'(light_a), 32'h0);
      check("alloff_warn",  32'(warn_a),  32'h0);
      all_off = 1'b0;  push_btn = 4'b0000;  tick();
      push_btn = 4'b1000;  tick();
      check("after_alloff_ch3", 32'(light_a), 32'h8);
      push_btn = 4'b0000;

      // Button held through reset and 50 cycles: no edge, normal timeout.
      for (int c = 1; c <= 51; c++) begin
         reset = (c == 1);  push_btn = 4'b0001;
         tick();
         e = seq(c, 6);
         check("held_light", 32'(light_a[0]), 32'(e[1]));
      end
      reset = 1'b0;
      push_btn = 4'b0000;  tick();
      for (int c = 1; c <= 32; c++) begin
         push_btn = (c == 1) ? 4'b0001 : 4'b0000;
         tick();
         e = seq(c, 6);
         check("repress_light", 32'(light_a[0]), 32'(e[1]));
         check("repress_warn",  32'(warn_a[0]),  32'(e[0]));
      end

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(15) == 0) push_btn[i] = ~push_btn[i];
         all_off = ($urandom_range(79) == 0);
         reset   = ($urandom_range(299) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
